// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: Tuse/Tnew codes,
// bypass-mux select codes, multiply/divide latencies and per-stage records.
package hazard_fwd_ctrl_pkg;

  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_D_RF  = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;
  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;
  localparam logic       FWD_M_REG = 1'b0;
  localparam logic       FWD_M_W   = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       is_md;
    logic       is_div;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
  } m_stage_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x != 2'd0) ? x - 2'd1 : 2'd0;
  endfunction

  // A producer still needing more cycles than the consumer can wait is an unresolvable RAW.
  function automatic logic raw_hazard(input logic [4:0] x, input logic [1:0] tuse,
                                      input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                      input logic [4:0] m_dst, input logic [1:0] m_tnew);
    return (tuse != TUSE_NONE) && (x != 5'd0) &&
           (((e_dst == x) && (e_tnew > tuse)) || ((m_dst == x) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage hazard descriptors in, stall / bypass selects / MD status out.
// No handshake: every signal is a level sampled or produced each cycle.
interface hazard_fwd_ctrl_if;
  logic [4:0] D_Rs;
  logic [4:0] D_Rt;
  logic [1:0] D_TuseRs;
  logic [1:0] D_TuseRt;
  logic [4:0] D_Dst;
  logic [1:0] D_Tnew;
  logic       D_IsMD;
  logic       D_IsDiv;
  logic       D_UsesMD;
  logic       Stall;
  logic [1:0] FwdD_Rs;
  logic [1:0] FwdD_Rt;
  logic [1:0] FwdE_Rs;
  logic [1:0] FwdE_Rt;
  logic       FwdM_Rt;
  logic       MD_Start;
  logic       MD_Busy;

  modport master (
    output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_Dst, D_Tnew, D_IsMD, D_IsDiv, D_UsesMD,
    input  Stall, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt, FwdM_Rt, MD_Start, MD_Busy
  );

  modport slave (
    input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_Dst, D_Tnew, D_IsMD, D_IsDiv, D_UsesMD,
    output Stall, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt, FwdM_Rt, MD_Start, MD_Busy
  );
endinterface

// File: rtl/hazard_fwd_ctrl_md_busy_counter.sv
// Multiply/divide busy counter: loaded as an MD instruction leaves E,
// then counts down to zero; busy while nonzero.
module md_busy_counter #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the D/E/M/W MIPS pipeline: tracks
// in-flight destinations and Tnew, drives stall and all operand-bypass selects.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  hazard_fwd_ctrl_if.slave bus
);

  e_stage_t   e_q, e_d;
  m_stage_t   m_q, m_d;
  logic [4:0] w_dst_q, w_dst_d;
  logic       md_busy;
  logic       stall;

  function automatic logic [1:0] fwd_d_sel(input logic [4:0] x);
    if (x == 5'd0)                                 return FWD_D_RF;
    else if (e_q.dst == x && e_q.tnew == TNEW_LINK) return FWD_D_E;
    else if (m_q.dst == x && m_q.tnew == 2'd0)      return FWD_D_M;
    else                                           return FWD_D_RF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] x);
    if (x == 5'd0)                             return FWD_E_REG;
    else if (m_q.dst == x && m_q.tnew == 2'd0) return FWD_E_M;
    else if (w_dst_q == x)                     return FWD_E_W;
    else                                       return FWD_E_REG;
  endfunction

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (e_q.is_md),
    .is_div (e_q.is_div),
    .busy   (md_busy)
  );

  // An MD instruction in E has not loaded the counter yet, so it must block MD users too.
  always_comb begin
    stall = raw_hazard(bus.D_Rs, bus.D_TuseRs, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew) |
            raw_hazard(bus.D_Rt, bus.D_TuseRt, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew) |
            (bus.D_UsesMD & (md_busy | e_q.is_md));

    m_d.rt   = e_q.rt;
    m_d.dst  = e_q.dst;
    m_d.tnew = sat_dec(e_q.tnew);
    w_dst_d  = m_q.dst;

    e_d = '0;
    if (!stall) begin
      e_d.rs     = bus.D_Rs;
      e_d.rt     = bus.D_Rt;
      e_d.dst    = bus.D_Dst;
      e_d.tnew   = bus.D_Tnew;
      e_d.is_md  = bus.D_IsMD;
      e_d.is_div = bus.D_IsDiv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q     <= '0;
      m_q     <= '0;
      w_dst_q <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_dst_q <= w_dst_d;
    end
  end

  assign bus.Stall    = stall;
  assign bus.FwdD_Rs  = fwd_d_sel(bus.D_Rs);
  assign bus.FwdD_Rt  = fwd_d_sel(bus.D_Rt);
  assign bus.FwdE_Rs  = fwd_e_sel(e_q.rs);
  assign bus.FwdE_Rt  = fwd_e_sel(e_q.rt);
  assign bus.FwdM_Rt  = (m_q.rt != 5'd0 && w_dst_q == m_q.rt) ? FWD_M_W : FWD_M_REG;
  assign bus.MD_Start = e_q.is_md;
  assign bus.MD_Busy  = md_busy;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: cycle-by-cycle vector table for the
// bypass/stall cases plus hand-written multiply/divide and reset sequences.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  hazard_fwd_ctrl_if hif ();

  hazard_fwd_ctrl dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (hif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tur;
    logic [1:0] tut;
    logic [4:0] dst;
    logic [1:0] tnew;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // expected = {stall, fwdd_rs, fwdd_rt, fwde_rs, fwde_rt, fwdm_rt, md_start, md_busy}
  function automatic logic [11:0] ex(logic st, logic [1:0] fdrs, logic [1:0] fdrt,
                                     logic [1:0] fers, logic [1:0] fert, logic fmrt);
    return {st, fdrs, fdrt, fers, fert, fmrt, 1'b0, 1'b0};
  endfunction

  task automatic add(string name, int rs, int rt, int tur, int tut, int dst, int tnew,
                     logic [11:0] e);
    vec_t v;
    v.name = name; v.rs = 5'(rs); v.rt = 5'(rt); v.tur = 2'(tur); v.tut = 2'(tut);
    v.dst = 5'(dst); v.tnew = 2'(tnew);
    vecs.push_back(v);
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [11:0] e);
    chk({tag, ".stall"},    hif.Stall,    e[11]);
    chk({tag, ".fwdd_rs"},  hif.FwdD_Rs,  e[10:9]);
    chk({tag, ".fwdd_rt"},  hif.FwdD_Rt,  e[8:7]);
    chk({tag, ".fwde_rs"},  hif.FwdE_Rs,  e[6:5]);
    chk({tag, ".fwde_rt"},  hif.FwdE_Rt,  e[4:3]);
    chk({tag, ".fwdm_rt"},  hif.FwdM_Rt,  e[2]);
    chk({tag, ".md_start"}, hif.MD_Start, e[1]);
    chk({tag, ".md_busy"},  hif.MD_Busy,  e[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(int rs, int rt, int tur, int tut, int dst, int tnew,
                       bit is_md, bit is_div, bit uses_md);
    hif.D_Rs = 5'(rs); hif.D_Rt = 5'(rt);
    hif.D_TuseRs = 2'(tur); hif.D_TuseRt = 2'(tut);
    hif.D_Dst = 5'(dst); hif.D_Tnew = 2'(tnew);
    hif.D_IsMD = is_md; hif.D_IsDiv = is_div; hif.D_UsesMD = uses_md;
  endtask

  task automatic drive_nop();
    drive(0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step_nops(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_nop();
    end
  endtask

  // MD instruction followed by mflo held in D while it stalls.
  task automatic run_md(string tag, bit is_div, int exp_stall);
    int cnt;
    @(negedge clk);
    drive(1, 2, 1, 1, 0, 0, 1'b1, is_div, 1'b1);
    #1;
    chk({tag, ".md_in_d_stall"}, hif.Stall, 1'b0);
    chk({tag, ".md_in_d_start"}, hif.MD_Start, 1'b0);
    @(negedge clk);
    drive(0, 0, 3, 3, 3, 1, 1'b0, 1'b0, 1'b1);
    #1;
    chk({tag, ".e_start"}, hif.MD_Start, 1'b1);
    chk({tag, ".e_busy"},  hif.MD_Busy,  1'b0);
    cnt = 0;
    while (hif.Stall === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
      if (cnt == 1) begin
        chk({tag, ".after_start"}, hif.MD_Start, 1'b0);
        chk({tag, ".after_busy"},  hif.MD_Busy,  1'b1);
      end
    end
    chk({tag, ".stall_cycles"}, cnt, exp_stall);
    chk({tag, ".release_busy"}, hif.MD_Busy, 1'b0);
    step_nops(3);
  endtask

  // ---------------- test ----------------
  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("reset", 12'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive_nop();
    step_nops(2);

    // addu $1 -> addu $3,$1,$2
    add("a_addu1", 2, 0, 1, 1, 1, 1, ex(0,0,0,0,0,0));
    add("a_addu3", 1, 2, 1, 1, 3, 1, ex(0,0,0,0,0,0));
    add("a_nop1",  0, 0, 3, 3, 0, 0, ex(0,0,0,1,0,0));
    add("a_nop2",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("a_nop3",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    // lw $2 -> addu $3,$2,$0
    add("b_lw",       29, 2, 1, 3, 2, 2, ex(0,0,0,0,0,0));
    add("b_addu_stl",  2, 0, 1, 1, 3, 1, ex(1,0,0,0,0,0));
    add("b_addu",      2, 0, 1, 1, 3, 1, ex(0,0,0,0,0,0));
    add("b_nop1",      0, 0, 3, 3, 0, 0, ex(0,0,0,2,0,0));
    add("b_nop2",      0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("b_nop3",      0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    // lw $2 -> beq $2,$0
    add("c_lw",      29, 2, 1, 3, 2, 2, ex(0,0,0,0,0,0));
    add("c_beq_stl1", 2, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0));
    add("c_beq_stl2", 2, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0));
    add("c_beq",      2, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0));
    add("c_nop1",     0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("c_nop2",     0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("c_nop3",     0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    // jal -> jr $31, then the same with a zero destination
    add("d_jal",    0, 0, 3, 3, 31, 0, ex(0,0,0,0,0,0));
    add("d_jr",    31, 0, 0, 3,  0, 0, ex(0,1,0,0,0,0));
    add("d_nop1",   0, 0, 3, 3,  0, 0, ex(0,0,0,1,0,0));
    add("d_nop2",   0, 0, 3, 3,  0, 0, ex(0,0,0,0,0,0));
    add("d_nop3",   0, 0, 3, 3,  0, 0, ex(0,0,0,0,0,0));
    add("d_link0",  0, 0, 3, 3,  0, 0, ex(0,0,0,0,0,0));
    add("d_jr0",   31, 0, 0, 3,  0, 0, ex(0,0,0,0,0,0));
    add("d_nop4",   0, 0, 3, 3,  0, 0, ex(0,0,0,0,0,0));
    add("d_nop5",   0, 0, 3, 3,  0, 0, ex(0,0,0,0,0,0));
    add("d_nop6",   0, 0, 3, 3,  0, 0, ex(0,0,0,0,0,0));
    // lw $5 -> sw $5 : no stall, store data forwarded at M
    add("f_lw",   29, 5, 1, 3, 5, 2, ex(0,0,0,0,0,0));
    add("f_sw",   29, 5, 1, 2, 0, 0, ex(0,0,0,0,0,0));
    add("f_nop1",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("f_nop2",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,1));
    add("f_nop3",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    // $4 produced by two stages at once: nearest wins
    add("g_addu4", 0, 0, 3, 3, 4, 1, ex(0,0,0,0,0,0));
    add("g_link4", 0, 0, 3, 3, 4, 0, ex(0,0,0,0,0,0));
    add("g_beq",   0, 4, 3, 0, 0, 0, ex(0,0,1,0,0,0));
    add("g_nop1",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,1,0));
    add("g_nop2",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,1));
    add("g_nop3",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    // ALU result from M to a branch in D
    add("h_addu6", 0, 0, 3, 3, 6, 1, ex(0,0,0,0,0,0));
    add("h_nop",   0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("h_beq",   6, 0, 0, 3, 0, 0, ex(0,2,0,0,0,0));
    add("h_nop1",  0, 0, 3, 3, 0, 0, ex(0,0,0,2,0,0));
    add("h_nop2",  0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    // addu $7 immediately followed by beq $7
    add("i_addu7",   0, 0, 3, 3, 7, 1, ex(0,0,0,0,0,0));
    add("i_beq_stl", 7, 0, 0, 3, 0, 0, ex(1,0,0,0,0,0));
    add("i_beq",     7, 0, 0, 3, 0, 0, ex(0,2,0,0,0,0));
    add("i_nop1",    0, 0, 3, 3, 0, 0, ex(0,0,0,2,0,0));
    add("i_nop2",    0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));
    add("i_nop3",    0, 0, 3, 3, 0, 0, ex(0,0,0,0,0,0));

    foreach (vecs[i]) begin
      logic [11:0] e;
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].tur, vecs[i].tut, vecs[i].dst, vecs[i].tnew,
            1'b0, 1'b0, 1'b0);
      #1;
      e = exp_q.pop_front();
      check_all(vecs[i].name, e);
    end

    run_md("div", 1'b1, 11);
    run_md("mult", 1'b0, 6);

    // reset pulled three cycles into a divide
    @(negedge clk);
    drive(1, 2, 1, 1, 0, 0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 0, 3, 3, 3, 1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.pre_busy",  hif.MD_Busy, 1'b1);
    chk("rst.pre_stall", hif.Stall,   1'b1);
    reset_n = 1'b0;
    #1;
    check_all("rst.async", 12'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive_nop();
    #1;
    check_all("rst.release", 12'd0);
    @(negedge clk);
    drive(0, 0, 3, 3, 3, 1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst.mflo_free", hif.Stall, 1'b0);
    step_nops(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
